// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - state, opcode and select encodings for the multicycle MIPS controller
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RTWB   = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pcwrite;
        logic       pcwritecond;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsource;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/mc_outdec.sv
// rtl/mc_outdec.sv - combinational state-to-control decoder for mc_control
module mc_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   memrdy,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.memread = 1'b1;
                ctrl.alusrcb = SRCB_FOUR;
                ctrl.aluop   = ALU_ADD;
                ctrl.irwrite = memrdy;
                ctrl.pcwrite = memrdy;
            end
            S_DECODE: begin
                ctrl.alusrcb = SRCB_IMMSH;
                ctrl.aluop   = ALU_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALU_ADD;
            end
            S_MEMRD: begin
                ctrl.memread = 1'b1;
                ctrl.iord    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            // Held across wait states; the memory commits only on its memrdy cycle.
            S_MEMWR: begin
                ctrl.memwrite = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_EXEC: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_B;
                ctrl.aluop   = ALU_FUNCT;
            end
            S_RTWB: begin
                ctrl.regdst   = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alusrca     = 1'b1;
                ctrl.alusrcb     = SRCB_B;
                ctrl.aluop       = ALU_SUB;
                ctrl.pcwritecond = 1'b1;
                ctrl.pcsource    = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pcwrite  = 1'b1;
                ctrl.pcsource = PCSRC_JUMP;
            end
            S_ADDIWB: begin
                ctrl.regwrite = 1'b1;
            end
            S_TRAP: begin
                ctrl.illegal = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// rtl/mc_control.sv - multicycle MIPS main controller; MC_CONTROL_TRAP_EN traps unknown opcodes
module mc_control
    import mips_ctrl_pkg::*;
#(
    parameter int ICNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [5:0]        opcode,
    input  logic              memrdy,
    output logic              pcwrite,
    output logic              pcwritecond,
    output logic              iord,
    output logic              memread,
    output logic              memwrite,
    output logic              irwrite,
    output logic              memtoreg,
    output logic              regdst,
    output logic              regwrite,
    output logic              alusrca,
    output logic [1:0]        alusrcb,
    output logic [1:0]        aluop,
    output logic [1:0]        pcsource,
    output logic [3:0]        state,
    output logic [ICNT_W-1:0] icount,
    output logic              illegal
);

    state_t            state_q, state_d;
    logic [ICNT_W-1:0] icount_q, icount_d;
    logic              retire;
    ctrl_t             ctrl;

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = memrdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
`ifdef MC_CONTROL_TRAP_EN
                    default:      state_d = S_TRAP;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = memrdy ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = memrdy ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_RTWB;
            S_ADDIEX: state_d = S_ADDIWB;
`ifdef MC_CONTROL_TRAP_EN
            S_TRAP:   state_d = S_TRAP;
`endif
            default:  state_d = S_FETCH;
        endcase
    end

    // Only completed instructions count; recovery from a stray encoding does not.
    always_comb begin
        retire = 1'b0;
        case (state_q)
            S_DECODE, S_MEMWB, S_MEMWR, S_RTWB, S_BRANCH, S_JUMP, S_ADDIWB:
                retire = (state_d == S_FETCH);
            default: retire = 1'b0;
        endcase
        icount_d = icount_q + {{(ICNT_W-1){1'b0}}, retire};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_FETCH;
            icount_q <= '0;
        end else begin
            state_q  <= state_d;
            icount_q <= icount_d;
        end
    end

    mc_outdec u_outdec (
        .state  (state_q),
        .memrdy (memrdy),
        .ctrl   (ctrl)
    );

    // Reset parks the FSM in FETCH, which would otherwise load PC/IR on memrdy.
    assign pcwrite     = ctrl.pcwrite  & rst_n;
    assign irwrite     = ctrl.irwrite  & rst_n;
    assign regwrite    = ctrl.regwrite & rst_n;
    assign memwrite    = ctrl.memwrite & rst_n;
    assign pcwritecond = ctrl.pcwritecond;
    assign iord        = ctrl.iord;
    assign memread     = ctrl.memread;
    assign memtoreg    = ctrl.memtoreg;
    assign regdst      = ctrl.regdst;
    assign alusrca     = ctrl.alusrca;
    assign alusrcb     = ctrl.alusrcb;
    assign aluop       = ctrl.aluop;
    assign pcsource    = ctrl.pcsource;
    assign state       = state_q;
    assign icount      = icount_q;
`ifdef MC_CONTROL_TRAP_EN
    assign illegal     = ctrl.illegal;
`else
    assign illegal     = 1'b0;
`endif

endmodule

// File: tb/tb_mc_control.sv
// tb/tb_mc_control.sv - scoreboard bench for mc_control against a per-instruction phase model
module tb_mc_control;

    localparam logic [5:0] T_RTYPE = 6'b000000;
    localparam logic [5:0] T_LW    = 6'b100011;
    localparam logic [5:0] T_SW    = 6'b101011;
    localparam logic [5:0] T_BEQ   = 6'b000100;
    localparam logic [5:0] T_J     = 6'b000010;
    localparam logic [5:0] T_ADDI  = 6'b001000;

    typedef struct packed {
        logic [3:0]  state;
        logic [15:0] icount;
        logic        illegal;
        logic        pcwrite;
        logic        pcwritecond;
        logic        iord;
        logic        memread;
        logic        memwrite;
        logic        irwrite;
        logic        memtoreg;
        logic        regdst;
        logic        regwrite;
        logic        alusrca;
        logic [1:0]  alusrcb;
        logic [1:0]  aluop;
        logic [1:0]  pcsource;
    } obs_t;

    typedef struct packed {
        logic [31:0] tag;
        obs_t        o;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        memrdy = 1'b0;
    logic        probe = 1'b0;
    logic [5:0]  opcode = 6'd0;
    logic        pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
    logic        memtoreg, regdst, regwrite, alusrca, illegal;
    logic [1:0]  alusrcb, aluop, pcsource;
    logic [3:0]  state;
    logic [15:0] icount;

    exp_t        exp_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          seq = 0;
    logic [15:0] icnt = 16'd0;

    always #5 clk = ~clk;

    mc_control #(.ICNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .memrdy(memrdy),
        .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
        .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
        .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
        .pcsource(pcsource), .state(state), .icount(icount), .illegal(illegal)
    );

    function automatic obs_t model(int st, logic rdy, logic [15:0] ic, logic rst_low);
        obs_t m;
        m = '0;
        m.state  = st[3:0];
        m.icount = ic;
        case (st)
            0:  begin m.memread = 1; m.alusrcb = 2'b01; m.irwrite = rdy; m.pcwrite = rdy; end
            1:  begin m.alusrcb = 2'b11; end
            2:  begin m.alusrca = 1; m.alusrcb = 2'b10; end
            3:  begin m.memread = 1; m.iord = 1; end
            4:  begin m.memtoreg = 1; m.regwrite = 1; end
            5:  begin m.memwrite = 1; m.iord = 1; end
            6:  begin m.alusrca = 1; m.aluop = 2'b10; end
            7:  begin m.regdst = 1; m.regwrite = 1; end
            8:  begin m.alusrca = 1; m.aluop = 2'b01; m.pcwritecond = 1; m.pcsource = 2'b01; end
            9:  begin m.pcwrite = 1; m.pcsource = 2'b10; end
            10: begin m.alusrca = 1; m.alusrcb = 2'b10; end
            11: begin m.regwrite = 1; end
            12: begin m.illegal = 1; end
            default: ;
        endcase
        if (rst_low) begin
            m.pcwrite = 0; m.irwrite = 0; m.regwrite = 0; m.memwrite = 0;
        end
        return m;
    endfunction

    always @(negedge clk or posedge probe) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            obs_t a;
            e = exp_q.pop_front();
            a.state = state;         a.icount = icount;       a.illegal = illegal;
            a.pcwrite = pcwrite;     a.pcwritecond = pcwritecond;
            a.iord = iord;           a.memread = memread;     a.memwrite = memwrite;
            a.irwrite = irwrite;     a.memtoreg = memtoreg;   a.regdst = regdst;
            a.regwrite = regwrite;   a.alusrca = alusrca;     a.alusrcb = alusrcb;
            a.aluop = aluop;         a.pcsource = pcsource;
            n_chk++;
            if (a !== e.o) begin
                n_fail++;
                $display("FAIL ctl_check tag=%0d state got=%0d want=%0d icount got=%0d want=%0d bits got=%h want=%h",
                         e.tag, a.state, e.o.state, a.icount, e.o.icount, a, e.o);
            end
        end
    end

    task automatic push_exp(int st, logic rdy, logic rst_low);
        exp_t e;
        seq++;
        e.tag = seq;
        e.o   = model(st, rdy, icnt, rst_low);
        exp_q.push_back(e);
    endtask

    task automatic cycle(int st, logic rdy, logic [5:0] op);
        @(posedge clk);
        #1;
        memrdy = rdy;
        opcode = op;
        push_exp(st, rdy, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        memrdy = 1'b1;
        icnt = 16'd0;
        #1;
        n_chk++;
        if (state !== 4'd0 || icount !== 16'd0 || regwrite !== 1'b0 || memwrite !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_check state=%0d icount=%0d regwrite=%b memwrite=%b",
                     state, icount, regwrite, memwrite);
        end
        push_exp(0, 1'b1, 1'b1);
        probe = 1'b1;
        #1 probe = 1'b0;
        @(posedge clk);
        #1;
        push_exp(0, 1'b1, 1'b1);
        probe = 1'b1;
        #1 probe = 1'b0;
        rst_n = 1'b1;
        memrdy = 1'b0;
    endtask

    function automatic bit is_legal(logic [5:0] op);
        return op == T_RTYPE || op == T_LW || op == T_SW || op == T_BEQ ||
               op == T_J || op == T_ADDI;
    endfunction

    task automatic run_instr(logic [5:0] op, int wf, int wm);
        int ph[$];
        case (op)
            T_LW:    ph = '{0, 1, 2, 3, 4};
            T_SW:    ph = '{0, 1, 2, 5};
            T_RTYPE: ph = '{0, 1, 6, 7};
            T_ADDI:  ph = '{0, 1, 10, 11};
            T_BEQ:   ph = '{0, 1, 8};
            T_J:     ph = '{0, 1, 9};
            default: ph = '{0, 1};
        endcase
        foreach (ph[i]) begin
            bit waitable;
            int reps;
            waitable = (ph[i] == 0 || ph[i] == 3 || ph[i] == 5);
            reps = (ph[i] == 0) ? wf : (waitable ? wm : 0);
            for (int r = 0; r <= reps; r++) begin
                logic rdy;
                logic [5:0] drv_op;
                rdy = waitable ? (r == reps) : 1'($urandom);
                drv_op = (ph[i] == 0) ? 6'($urandom) : op;
                cycle(ph[i], rdy, drv_op);
                if (waitable && r == reps) begin
                    n_chk++;
                    if (state !== 4'(ph[i])) begin
                        n_fail++;
                        $display("FAIL wait_check phase=%0d waits=%0d state=%0d", ph[i], reps, state);
                    end
                end
            end
        end
        icnt = icnt + 16'd1;
    endtask

    task automatic trap_run(logic [5:0] op);
        cycle(0, 1'b1, 6'($urandom));
        cycle(1, 1'b1, op);
        for (int k = 0; k < 10; k++) cycle(12, 1'($urandom), op);
    endtask

    initial begin
        logic [5:0] legal_ops[6];
        logic [5:0] op;
        legal_ops = '{T_RTYPE, T_LW, T_SW, T_BEQ, T_J, T_ADDI};

        do_reset();
        run_instr(T_LW, 0, 0);
        run_instr(T_SW, 0, 2);
        run_instr(T_BEQ, 0, 0);
        run_instr(T_J, 1, 0);
        run_instr(T_RTYPE, 0, 0);
        run_instr(T_ADDI, 2, 0);
        run_instr(T_LW, 1, 3);

        cycle(0, 1'b1, 6'($urandom));
        cycle(1, 1'b1, T_LW);
        cycle(2, 1'b1, T_LW);
        cycle(3, 1'b0, T_LW);
        do_reset();

`ifndef MC_CONTROL_TRAP_EN
        run_instr(6'b111111, 0, 0);
`endif
        run_instr(T_ADDI, 0, 0);

        for (int n = 0; n < 150; n++) begin
            int k;
            int wf;
            int wm;
`ifdef MC_CONTROL_TRAP_EN
            k = $urandom_range(0, 5);
`else
            k = $urandom_range(0, 7);
`endif
            if (k < 6) begin
                op = legal_ops[k];
            end else begin
                op = 6'($urandom);
                while (is_legal(op)) op = 6'($urandom);
            end
            wf = $urandom_range(0, 2);
            wm = $urandom_range(0, 2);
            run_instr(op, wf, wm);
        end

`ifdef MC_CONTROL_TRAP_EN
        trap_run(6'b111111);
        do_reset();
        run_instr(T_LW, 0, 0);
`endif

        @(negedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multicycle MIPS main controller. Sequences the shared datapath (PC, unified instruction/data memory, IR, register file, ALU) through fetch/decode/execute/memory/writeback steps.
- Drives the same control signal set as the single-cycle decoder (regdst, alusrc, memtoreg, regwrite, memread, memwrite, aluop), plus multicycle mux/enable controls.
- Inserts wait states on memory accesses via a ready handshake.

Parameters:
- ICNT_W, 16, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26], valid from DECODE onward.
- memrdy  in  1  memory access completes this cycle.
- pcwrite  out  1  unconditional PC load.
- pcwritecond  out  1  PC load if ALU zero (beq).
- iord  out  1  0 = memory address from PC, 1 = from ALUOut.
- memread  out  1  memory read request.
- memwrite  out  1  memory write request.
- irwrite  out  1  IR load.
- memtoreg  out  1  register write data from MDR.
- regdst  out  1  1 = rd, 0 = rt.
- regwrite  out  1  register file write enable.
- alusrca  out  1  0 = PC, 1 = A.
- alusrcb  out  2  00 = B, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- aluop  out  2  00 = add, 01 = sub, 10 = funct field.
- pcsource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- state  out  4  current state (debug).
- icount  out  ICNT_W  retired instructions.
- illegal  out  1  trap flag (optional feature only; tied 0 otherwise).

Behaviour:
- Moore FSM, 4-bit state register, asynchronous reset to FETCH; icount resets to 0.
- Outputs are combinational decode of state; default 0.
- While rst_n is low, pcwrite, irwrite, regwrite and memwrite are forced 0.
- Opcodes: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, J 000010, ADDI 001000.
- FETCH (0): memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsource=00.
  - irwrite=memrdy, pcwrite=memrdy.
  - Stay while memrdy=0; go to DECODE when memrdy=1.
- DECODE (1): alusrca=0, alusrcb=11, aluop=00. Next state by opcode:
  - LW or SW -> MEMADR
  - RTYPE -> EXEC
  - BEQ -> BRANCH
  - J -> JUMP
  - ADDI -> ADDIEX
  - any other opcode -> FETCH (treated as nop).
- MEMADR (2): alusrca=1, alusrcb=10, aluop=00. LW -> MEMRD; SW -> MEMWR.
- MEMRD (3): memread=1, iord=1. Hold until memrdy, then -> MEMWB.
- MEMWB (4): regdst=0, memtoreg=1, regwrite=1 -> FETCH.
- MEMWR (5): memwrite=1, iord=1. Hold until memrdy, then -> FETCH.
  - memwrite stays high for every wait cycle; memory commits once, on the memrdy cycle.
- EXEC (6): alusrca=1, alusrcb=00, aluop=10 -> RTWB.
- RTWB (7): regdst=1, memtoreg=0, regwrite=1 -> FETCH.
- BRANCH (8): alusrca=1, alusrcb=00, aluop=01, pcwritecond=1, pcsource=01 -> FETCH.
- JUMP (9): pcwrite=1, pcsource=10 -> FETCH.
- ADDIEX (10): alusrca=1, alusrcb=10, aluop=00 -> ADDIWB.
- ADDIWB (11): regdst=0, memtoreg=0, regwrite=1 -> FETCH.
- Unused encodings (12–15) -> FETCH next cycle; all outputs 0.
- Cycle counts with memrdy held high:
  - LW 5
  - SW 4
  - R-type 4
  - ADDI 4
  - BEQ 3
  - J 3
  - decode-nop 2
  - Each memrdy=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- icount increments by 1 on every transition into FETCH from states 1, 4, 5, 7, 8, 9 or 11; wraps modulo 2^ICNT_W.
- Reset mid-instruction: state returns to FETCH immediately; no partial write completes after rst_n falls.

Optional Feature:
- Macro: MC_CONTROL_TRAP_EN.
- Defined:
  - Unknown opcode in DECODE -> TRAP (12).
  - TRAP drives all control outputs 0 and sets illegal=1.
  - TRAP is held until reset; icount does not increment.
- Undefined: unknown opcode -> FETCH as nop (counted in icount); state 12 is unused; illegal tied 0.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state encodings S_FETCH through S_TRAP
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - ALUOp codes ALU_ADD, ALU_SUB, ALU_FUNCT
  - alusrcb and pcsource select codes.
- One sub-module, mc_outdec: purely combinational state-to-control-signal decoder. mc_control keeps the state register, next-state logic and icount.

Test Plan:
- Reset then memrdy=1, opcode=100011 -> state sequence 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4; icount=1.
- opcode=101011, memrdy low for 2 cycles in MEMWR -> memwrite=1 for 3 consecutive cycles; next state 0; total 6 cycles.
- opcode=000100 then opcode=000010 -> BRANCH asserts pcwritecond=1, pcsource=01; JUMP asserts pcwrite=1, pcsource=10; icount=2.
- opcode=000000 then opcode=001000 -> RTWB has regdst=1; ADDIWB has regdst=0, alusrcb=10 in state 10; each takes 4 cycles.
- rst_n pulsed low while state=3 -> state=0 asynchronously; regwrite never asserted; icount=0.
- opcode=111111 -> without macro: state returns to 0 after 2 cycles, icount=1. With MC_CONTROL_TRAP_EN: state=12, illegal=1 held for 10 cycles, icount unchanged.
